piso_tx_scheduler: RTL and testbench
====================================

Name: piso_tx_scheduler

Overview:
- Two-requester scheduler for a D_SIZE-bit parallel-in/serial-out transmit path.
- Arbitrates round-robin between two parallel-word requesters over valid/ready handshakes.
- Loads the winning word into an internal shift register, then frames it on one serial line: start bit, then data MSB-first.
- Inserts a programmable idle gap between frames; sits between word producers and the serial link.

Parameters:
- D_SIZE, 4: data word width in bits (>=2).
- GAP, 1: idle cycles inserted after each frame before the next grant (>=0).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  D_SIZE  requester 0 word.
- req0_ready  output  1  requester 0 handshake accept.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  D_SIZE  requester 1 word.
- req1_ready  output  1  requester 1 handshake accept.
- serial_out  output  1  serial line.
- frame_active  output  1  high while start/data bits are on serial_out.
- grant_id  output  1  source of the current or most recent frame.
- done  output  1  one-cycle pulse on the last data bit.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State IDLE; serial_out=0, frame_active=0, done=0, grant_id=0.
  - Round-robin pointer last_grant=1, so requester 0 wins the first tie.
  - req0_ready=req1_ready=0 while rst=0 (combinational gate).
- FSM states: IDLE, START, SHIFT, GAP.
- Ready generation:
  - Readies are combinational and asserted only in IDLE with rst=1; at most one is high.
  - sel = the only valid requester; if both are valid, sel = the requester that is not last_grant.
  - reqX_ready = IDLE && reqX_valid && sel==X. No ready is asserted when no valid is present.
- IDLE, on handshake (valid&&ready) at edge T:
  - shift register <= reqX_data; grant_id <= X; last_grant <= X; go to START.
  - Data changes after T do not affect the frame.
- START (cycle T+1): serial_out=1 (start bit), frame_active=1; go to SHIFT.
- SHIFT (cycles T+2 .. T+1+D_SIZE):
  - serial_out = data bit D_SIZE-1 down to 0, one bit per cycle; frame_active=1.
  - done=1 only in cycle T+1+D_SIZE.
  - After the last bit: go to GAP, or to IDLE if GAP=0.
- GAP: serial_out=0, frame_active=0 for exactly GAP cycles, then IDLE.
- Line idle level is 0; serial_out, frame_active, done and grant_id are registered outputs.
- Throughput: minimum handshake-to-handshake period is D_SIZE+2+GAP cycles, counting the single IDLE cycle.
- Counters:
  - Bit counter wraps only via the state transition; no state is reachable other than the four listed.
  - GAP counter is unused when GAP=0.
- Reset mid-frame (any state):
  - Frame is aborted; the cycle after the reset edge shows serial_out=0, frame_active=0, done=0.
  - No partial done; pointer returns to last_grant=1.
- A requester dropping valid before its handshake is legal and has no effect.
- Valid arriving in START/SHIFT/GAP waits; it is sampled in IDLE.
- grant_id holds its value through GAP/IDLE until the next handshake.

Test Plan:
- Reset: hold rst=0 for 2 cycles with both valids high -> readies 0, serial_out=0, frame_active=0, done=0, grant_id=0.
- Single frame: req0_valid=1, req0_data=4'b1011, GAP=1, handshake at T -> serial_out 1,1,0,1,1 in cycles T+1..T+5; frame_active=1 in T+1..T+5; done=1 only in T+5; grant_id=0; serial_out=0 in T+6; next ready possible in T+7.
- Contention: both valid continuously, req0_data=4'hA, req1_data=4'h5 -> grants 0,1,0,1 in that order; frames carry 1_1010 then 1_0101; handshakes spaced exactly 7 cycles apart.
- Single requester streaming: only req1_valid=1 with 4'hF -> consecutive grants all to req1 (grant_id=1); 7-cycle period; each frame shows five 1s followed by one 0 gap cycle.
- Mid-frame reset: rst=0 for one edge during the 2nd data bit -> next cycle serial_out=0, frame_active=0, no done pulse; after release, req0 frame with 4'b0110 transmits 1,0,1,1,0 cleanly.
- Data stability: change req0_data from 4'h9 to 4'h6 the cycle after the handshake -> transmitted bits 1,1,0,0,1 (latched 4'h9).

Source files
------------

// File: rtl/piso_tx_scheduler.sv
// piso_tx_scheduler: two-requester round-robin scheduler feeding a parallel-in/serial-out
// transmitter. Each granted word is framed as a start bit (1) followed by its data bits
// MSB-first on serial_out, then the line rests at 0 for GAP idle cycles before the next grant.
module piso_tx_scheduler #(
    parameter int D_SIZE = 4,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [D_SIZE-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [D_SIZE-1:0] req1_data,
    output logic              req1_ready,
    output logic              serial_out,
    output logic              frame_active,
    output logic              grant_id,
    output logic              done
);

    // Bit counter counts data bits already placed on the line, 0..D_SIZE.
    localparam int CNT_W    = $clog2(D_SIZE + 1);
    // Gap counter only needs to reach GAP-1; keep at least one bit so GAP=0 still elaborates.
    localparam int GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t              state_q;
    logic [D_SIZE-1:0]   shreg_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [GAP_W-1:0]    gap_cnt_q;
    logic                last_grant_q;
    logic                grant_id_q;
    logic                serial_q;
    logic                active_q;
    logic                done_q;

    logic                sel_d;
    logic                idle_ok_d;
    logic                accept_d;
    logic                last_bit_sent_d;

    // Arbitration: a lone valid wins outright, a tie goes to whoever was not granted last.
    always_comb begin
        sel_d           = 1'b0;
        idle_ok_d       = 1'b0;
        last_bit_sent_d = 1'b0;
        if (req0_valid && req1_valid) begin
            sel_d = ~last_grant_q;
        end else begin
            sel_d = req1_valid;
        end
        // Readies are gated by reset so nothing is accepted while rst is held low.
        idle_ok_d       = rst && (state_q == S_IDLE);
        last_bit_sent_d = (bit_cnt_q == CNT_W'(D_SIZE));
    end

    assign req0_ready = idle_ok_d && req0_valid && !sel_d;
    assign req1_ready = idle_ok_d && req1_valid &&  sel_d;
    assign accept_d   = req0_ready || req1_ready;

    // Frame sequencer: state, counters, round-robin pointer and all registered line outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            serial_q     <= 1'b0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    serial_q <= 1'b0;
                    active_q <= 1'b0;
                    if (accept_d) begin
                        // Outputs are registered, so the start bit is launched on the grant edge.
                        state_q      <= S_START;
                        serial_q     <= 1'b1;
                        active_q     <= 1'b1;
                        grant_id_q   <= sel_d;
                        last_grant_q <= sel_d;
                        bit_cnt_q    <= '0;
                    end
                end
                S_START: begin
                    state_q   <= S_SHIFT;
                    serial_q  <= shreg_q[D_SIZE-1];
                    active_q  <= 1'b1;
                    bit_cnt_q <= CNT_W'(1);
                end
                S_SHIFT: begin
                    if (last_bit_sent_d) begin
                        serial_q  <= 1'b0;
                        active_q  <= 1'b0;
                        bit_cnt_q <= '0;
                        gap_cnt_q <= '0;
                        if (GAP == 0) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end else begin
                        serial_q  <= shreg_q[D_SIZE-1];
                        active_q  <= 1'b1;
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        // The bit being launched now is the last one when D_SIZE-1 are already out.
                        done_q    <= (bit_cnt_q == CNT_W'(D_SIZE - 1));
                    end
                end
                S_GAP: begin
                    serial_q <= 1'b0;
                    active_q <= 1'b0;
                    if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
                        state_q   <= S_IDLE;
                        gap_cnt_q <= '0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    serial_q <= 1'b0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    // Shift register: captures the winning word on the grant edge, then shifts out MSB-first.
    always_ff @(posedge clk) begin
        if (accept_d) begin
            shreg_q <= sel_d ? req1_data : req0_data;
        end else if ((state_q == S_START) || ((state_q == S_SHIFT) && !last_bit_sent_d)) begin
            shreg_q <= {shreg_q[D_SIZE-2:0], 1'b0};
        end
    end

    assign serial_out   = serial_q;
    assign frame_active = active_q;
    assign grant_id     = grant_id_q;
    assign done         = done_q;

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Directed bench for piso_tx_scheduler with D_SIZE=4, GAP=1.
module tb_piso_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0;
    logic [3:0] req0_data = 4'h0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [3:0] req1_data = 4'h0;
    logic       req1_ready;
    logic       serial_out;
    logic       frame_active;
    logic       grant_id;
    logic       done;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    piso_tx_scheduler #(.D_SIZE(4), .GAP(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .serial_out   (serial_out),
        .frame_active (frame_active),
        .grant_id     (grant_id),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step;
        step;
        rst = 1'b1;
    endtask

    // Waits (bounded) until some ready is high; reports which ones. Both 0 means timeout.
    task automatic wait_ready(output logic r0, output logic r1);
        bit found;
        found = 0;
        r0 = 1'b0;
        r1 = 1'b0;
        #1;
        for (int n = 0; n < 30 && !found; n++) begin
            if (req0_ready || req1_ready) begin
                found = 1;
                r0 = req0_ready;
                r1 = req1_ready;
            end else begin
                step;
            end
        end
    endtask

    // Called in the cycle before handshake edge T; records cycles T+1..T+6 (MSB = T+1).
    task automatic record(input bit chg, input logic [3:0] newd,
                          output logic [5:0] so, output logic [5:0] fa,
                          output logic [5:0] dn, output logic gid, output int t);
        step;
        t = cyc;
        gid = grant_id;
        if (chg) req0_data = newd;
        for (int k = 0; k < 6; k++) begin
            so[5-k] = serial_out;
            fa[5-k] = frame_active;
            dn[5-k] = done;
            if (k < 5) step;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 4'h3;  req1_data = 4'h5;
        step;
        step;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b want 0", req1_ready); end
        checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL reset_serial: got %b want 0", serial_out); end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", frame_active); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b want 0", grant_id); end
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL idle_novalid_ready: got %b want 00", {req0_ready, req1_ready}); end
    endtask

    task automatic test_single_frame;
        logic r0, r1, gid;
        logic [5:0] so, fa, dn;
        int t;
        do_reset;
        req0_data = 4'b1011; req0_valid = 1'b1;
        wait_ready(r0, r1);
        checks++; if ({r0, r1} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b want 10", {r0, r1}); end
        record(0, 4'h0, so, fa, dn, gid, t);
        checks++; if (so !== 6'b110110) begin errors++; $display("FAIL single_serial: got %b want 110110", so); end
        checks++; if (fa !== 6'b111110) begin errors++; $display("FAIL single_active: got %b want 111110", fa); end
        checks++; if (dn !== 6'b000010) begin errors++; $display("FAIL single_done: got %b want 000010", dn); end
        checks++; if (gid !== 1'b0) begin errors++; $display("FAIL single_grant: got %b want 0", gid); end
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL single_gap_ready: got %b want 0", req0_ready); end
        step;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_next_ready: got %b want 1", req0_ready); end
        req0_valid = 1'b0;
        #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL single_drop_ready: got %b want 0", req0_ready); end
        step;
        step;
        checks++; if ({serial_out, frame_active} !== 2'b00) begin errors++; $display("FAIL single_drop_line: got %b want 00", {serial_out, frame_active}); end
    endtask

    task automatic test_contention;
        logic r0, r1, gid;
        logic [5:0] so, fa, dn, exp_so;
        int t, tprev;
        logic id;
        do_reset;
        req0_data = 4'hA; req1_data = 4'h5;
        req0_valid = 1'b1; req1_valid = 1'b1;
        tprev = 0;
        for (int i = 0; i < 4; i++) begin
            id = (i % 2 == 1);
            wait_ready(r0, r1);
            checks++; if ({r0, r1} !== {~id, id}) begin errors++; $display("FAIL contention_ready%0d: got %b want %b", i, {r0, r1}, {~id, id}); end
            record(0, 4'h0, so, fa, dn, gid, t);
            exp_so = id ? 6'b101010 : 6'b110100;
            checks++; if (so !== exp_so) begin errors++; $display("FAIL contention_serial%0d: got %b want %b", i, so, exp_so); end
            checks++; if (gid !== id) begin errors++; $display("FAIL contention_grant%0d: got %b want %b", i, gid, id); end
            if (i > 0) begin
                checks++; if (t - tprev !== 7) begin errors++; $display("FAIL contention_period%0d: got %0d want 7", i, t - tprev); end
            end
            tprev = t;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_streaming;
        logic r0, r1, gid;
        logic [5:0] so, fa, dn;
        int t, tprev;
        do_reset;
        req1_data = 4'hF; req1_valid = 1'b1;
        tprev = 0;
        for (int i = 0; i < 3; i++) begin
            wait_ready(r0, r1);
            checks++; if ({r0, r1} !== 2'b01) begin errors++; $display("FAIL stream_ready%0d: got %b want 01", i, {r0, r1}); end
            record(0, 4'h0, so, fa, dn, gid, t);
            checks++; if (so !== 6'b111110) begin errors++; $display("FAIL stream_serial%0d: got %b want 111110", i, so); end
            checks++; if (gid !== 1'b1) begin errors++; $display("FAIL stream_grant%0d: got %b want 1", i, gid); end
            checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL stream_grant_hold%0d: got %b want 1", i, grant_id); end
            if (i > 0) begin
                checks++; if (t - tprev !== 7) begin errors++; $display("FAIL stream_period%0d: got %0d want 7", i, t - tprev); end
            end
            tprev = t;
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_midframe_reset;
        logic r0, r1, gid;
        logic [5:0] so, fa, dn;
        int t;
        bit saw_done;
        do_reset;
        req0_data = 4'hF; req0_valid = 1'b1;
        wait_ready(r0, r1);
        step;
        req0_valid = 1'b0;
        step;
        step;
        checks++; if ({serial_out, frame_active} !== 2'b11) begin errors++; $display("FAIL mid_second_bit: got %b want 11", {serial_out, frame_active}); end
        rst = 1'b0;
        step;
        checks++; if ({serial_out, frame_active, done} !== 3'b000) begin errors++; $display("FAIL mid_abort: got %b want 000", {serial_out, frame_active, done}); end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL mid_ready_gate: got %b want 00", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b1;
        saw_done = 0;
        for (int k = 0; k < 4; k++) begin
            if (done !== 1'b0 || frame_active !== 1'b0) saw_done = 1;
            step;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL mid_no_partial: got 1 want 0"); end
        req0_data = 4'b0110; req1_data = 4'h9;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_ready(r0, r1);
        checks++; if ({r0, r1} !== 2'b10) begin errors++; $display("FAIL mid_pointer: got %b want 10", {r0, r1}); end
        record(0, 4'h0, so, fa, dn, gid, t);
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if (so !== 6'b101100) begin errors++; $display("FAIL mid_after_serial: got %b want 101100", so); end
        checks++; if (dn !== 6'b000010) begin errors++; $display("FAIL mid_after_done: got %b want 000010", dn); end
    endtask

    task automatic test_data_stability;
        logic r0, r1, gid;
        logic [5:0] so, fa, dn;
        int t;
        do_reset;
        req0_data = 4'h9; req0_valid = 1'b1;
        wait_ready(r0, r1);
        checks++; if ({r0, r1} !== 2'b10) begin errors++; $display("FAIL stable_ready: got %b want 10", {r0, r1}); end
        record(1, 4'h6, so, fa, dn, gid, t);
        req0_valid = 1'b0;
        checks++; if (so !== 6'b110010) begin errors++; $display("FAIL stable_serial: got %b want 110010", so); end
        checks++; if (fa !== 6'b111110) begin errors++; $display("FAIL stable_active: got %b want 111110", fa); end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_contention;
        test_streaming;
        test_midframe_reset;
        test_data_stability;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
